// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neuron datapath: feeder FSM states,
// default beat/threshold widths shared with the neuron, and an address-width
// helper that never returns zero.
package bnn_pkg;

   localparam int BNN_PW       = 8;
   localparam int BNN_THRESH_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

   // $clog2 with a floor of 1 so that degenerate sizes still get a real port.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/act_beat_buffer.sv
// Purpose : DEPTH x PW activation register file, gated write, async read.
// Latency : write visible the cycle after wr_en; read is combinational.
// Backpressure: none; writer gates wr_en itself (feeder blocks writes mid-pass).
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data read port.
// Contents are deliberately not reset.
module act_beat_buffer
   import bnn_pkg::*;
#(
   parameter int PW    = BNN_PW,
   parameter int DEPTH = 4,
   parameter int AW    = clog2_min1(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [PW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [PW-1:0] rd_data
);

   logic [PW-1:0] mem_q [DEPTH];

   // Out-of-range addresses (non power-of-two DEPTH) are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < DEPTH)) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/neuron_beat_feeder.sv
// Purpose : sequence one activation vector against NUM_NEURONS weight rows,
//           emitting IN_BEATS {x, w} beats per neuron plus its threshold.
// Latency : 1 cycle from memory read issue to beat on valid_out.
// Backpressure: pause stalls read issue; beats already issued still emerge,
//           leaving valid_out=0 gaps.
// Ports: clk/rst (async, active-high); act_wr_* loads the activation buffer
//        (ignored while busy); start/pause control; w_rd_*/t_rd_* drive the
//        external weight/threshold memories (1-cycle read latency);
//        x/w/threshold/valid_out/last form the beat stream; busy/done status.
// Optional: NEURON_FEEDER_PERF_CNT_EN adds cycle_cnt (busy cycles per pass).
module neuron_beat_feeder
   import bnn_pkg::*;
#(
   parameter int PW          = BNN_PW,
   parameter int THRESH_W    = BNN_THRESH_W,
   parameter int IN_BEATS    = 4,
   parameter int NUM_NEURONS = 3,
   parameter int WADDR_W     = clog2_min1(IN_BEATS * NUM_NEURONS),
   parameter int TADDR_W     = clog2_min1(NUM_NEURONS),
   parameter int AADDR_W     = clog2_min1(IN_BEATS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                act_wr_en,
   input  logic [AADDR_W-1:0]  act_wr_addr,
   input  logic [PW-1:0]       act_wr_data,
   input  logic                start,
   input  logic                pause,
   output logic                w_rd_en,
   output logic [WADDR_W-1:0]  w_rd_addr,
   input  logic [PW-1:0]       w_rd_data,
   output logic                t_rd_en,
   output logic [TADDR_W-1:0]  t_rd_addr,
   input  logic [THRESH_W-1:0] t_rd_data,
   output logic [PW-1:0]       x,
   output logic [PW-1:0]       w,
   output logic [THRESH_W-1:0] threshold,
   output logic                valid_out,
   output logic                last,
   output logic                busy,
   output logic                done
`ifdef NEURON_FEEDER_PERF_CNT_EN
   ,
   output logic [31:0]         cycle_cnt
`endif
);

   feeder_state_t       state_q, state_d;
   logic [AADDR_W-1:0]  beat_q, beat_d;
   logic [TADDR_W-1:0]  neuron_q, neuron_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PW-1:0]       x_q, x_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [THRESH_W-1:0] thr_hold_q, thr_hold_d;

   logic                issue;
   logic                beat_last;
   logic                neuron_last;
   logic                start_ok;
   logic [PW-1:0]       buf_rd_data;

   assign beat_last   = (beat_q == AADDR_W'(IN_BEATS - 1));
   assign neuron_last = (neuron_q == TADDR_W'(NUM_NEURONS - 1));
   assign start_ok    = (state_q == IDLE) && start;

   // Buffer is frozen for the whole pass; an IDLE write coinciding with
   // start lands before the first read.
   act_beat_buffer #(
      .PW    (PW),
      .DEPTH (IN_BEATS),
      .AW    (AADDR_W)
   ) u_act_buf (
      .clk     (clk),
      .wr_en   (act_wr_en && (state_q == IDLE)),
      .wr_addr (act_wr_addr),
      .wr_data (act_wr_data),
      .rd_addr (beat_q),
      .rd_data (buf_rd_data)
   );

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      neuron_d = neuron_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      issue    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = RUN;
               busy_d   = 1'b1;
               beat_d   = '0;
               neuron_d = '0;
            end
         end
         RUN: begin
            if (!pause) begin
               issue = 1'b1;
               if (beat_last) begin
                  beat_d = '0;
                  // Counters return to 0 after the final issue so the
                  // address never reaches IN_BEATS*NUM_NEURONS.
                  if (neuron_last) begin
                     neuron_d = '0;
                     state_d  = DRAIN;
                  end else begin
                     neuron_d = neuron_q + TADDR_W'(1);
                  end
               end else begin
                  beat_d = beat_q + AADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            // Final weight word is on the bus this cycle.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      x_d        = issue ? buf_rd_data : x_q;
      valid_d    = issue;
      last_d     = issue && beat_last;
      thr_hold_d = last_q ? t_rd_data : thr_hold_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         neuron_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         x_q        <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         thr_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         neuron_q   <= neuron_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         x_q        <= x_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         thr_hold_q <= thr_hold_d;
      end
   end

   assign w_rd_en   = issue;
   assign w_rd_addr = WADDR_W'(neuron_q) * WADDR_W'(IN_BEATS) + WADDR_W'(beat_q);
   assign t_rd_en   = issue && beat_last;
   assign t_rd_addr = neuron_q;

   assign x         = x_q;
   assign w         = w_rd_data;
   // Threshold arrives with the last beat; bypass it that cycle, hold after.
   assign threshold = last_q ? t_rd_data : thr_hold_q;
   assign valid_out = valid_q;
   assign last      = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef NEURON_FEEDER_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (start_ok) begin
         cycle_cnt_d = '0;
      end else if (busy_q) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_neuron_beat_feeder.sv
module tb_neuron_beat_feeder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A: IN_BEATS=4, NUM_NEURONS=3 ----------------
   logic        act_wr_en, start, pause;
   logic [1:0]  act_wr_addr;
   logic [7:0]  act_wr_data;
   logic        w_rd_en, t_rd_en;
   logic [3:0]  w_rd_addr;
   logic [1:0]  t_rd_addr;
   logic [7:0]  w_rd_data;
   logic [15:0] t_rd_data;
   logic [7:0]  x, w;
   logic [15:0] threshold;
   logic        valid_out, last, busy, done;
`ifdef NEURON_FEEDER_PERF_CNT_EN
   logic [31:0] cycle_cnt;
`endif

   neuron_beat_feeder #(.PW(8), .THRESH_W(16), .IN_BEATS(4), .NUM_NEURONS(3)) dut (
      .clk(clk), .rst(rst),
      .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
      .start(start), .pause(pause),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .t_rd_en(t_rd_en), .t_rd_addr(t_rd_addr), .t_rd_data(t_rd_data),
      .x(x), .w(w), .threshold(threshold), .valid_out(valid_out), .last(last),
      .busy(busy), .done(done)
`ifdef NEURON_FEEDER_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt)
`endif
   );

   // ---------------- DUT B: IN_BEATS=1, NUM_NEURONS=2 ----------------
   logic        act1_wr_en, start1, pause1;
   logic [0:0]  act1_wr_addr;
   logic [7:0]  act1_wr_data;
   logic        w1_rd_en, t1_rd_en;
   logic [0:0]  w1_rd_addr;
   logic [0:0]  t1_rd_addr;
   logic [7:0]  w1_rd_data;
   logic [15:0] t1_rd_data;
   logic [7:0]  x1, w1;
   logic [15:0] threshold1;
   logic        valid1, last1, busy1, done1;
`ifdef NEURON_FEEDER_PERF_CNT_EN
   logic [31:0] cycle_cnt1;
`endif

   neuron_beat_feeder #(.PW(8), .THRESH_W(16), .IN_BEATS(1), .NUM_NEURONS(2)) dut1 (
      .clk(clk), .rst(rst),
      .act_wr_en(act1_wr_en), .act_wr_addr(act1_wr_addr), .act_wr_data(act1_wr_data),
      .start(start1), .pause(pause1),
      .w_rd_en(w1_rd_en), .w_rd_addr(w1_rd_addr), .w_rd_data(w1_rd_data),
      .t_rd_en(t1_rd_en), .t_rd_addr(t1_rd_addr), .t_rd_data(t1_rd_data),
      .x(x1), .w(w1), .threshold(threshold1), .valid_out(valid1), .last(last1),
      .busy(busy1), .done(done1)
`ifdef NEURON_FEEDER_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt1)
`endif
   );

   // External memories: weight[i] = i, thresholds {10,20,30}, 1-cycle read.
   int thr_m [3] = '{10, 20, 30};
   always @(posedge clk) begin
      if (w_rd_en)  w_rd_data  <= 8'(w_rd_addr);
      if (t_rd_en)  t_rd_data  <= 16'(thr_m[t_rd_addr]);
      if (w1_rd_en) w1_rd_data <= 8'(w1_rd_addr);
      if (t1_rd_en) t1_rd_data <= 16'(thr_m[t1_rd_addr]);
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [7:0]  x;
      logic [7:0]  w;
      logic        last;
      logic [15:0] thr;
   } beat_t;

   beat_t exp_q[$], log_q[$], exp1_q[$];
   int    addr_q[$], taddr_q[$];
   logic [7:0] act_m [4];
   logic [7:0] act1_m;

   int vectors = 0, miscompares = 0;
   int done_cnt = 0, done_cyc = 0, done1_cnt = 0, done1_cyc = 0;
   int beats_seen = 0, beats1_seen = 0;
   int first_cyc = -1, last_cyc = 0, start_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected stream for one pass: neuron-major, beat-minor.
   task automatic push_pass();
      for (int n = 0; n < 3; n++) begin
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{act_m[b], 8'(n * 4 + b), (b == 3), 16'(thr_m[n])});
            addr_q.push_back(n * 4 + b);
         end
         taddr_q.push_back(n);
      end
   endtask

   always @(negedge clk) begin : compare
      beat_t e;
      if (!rst) begin
         if (w_rd_en) begin
            if (addr_q.size() == 0) chk("w_rd_unexpected", 32'(w_rd_addr), 32'hFFFF);
            else chk("w_rd_addr", 32'(w_rd_addr), 32'(addr_q.pop_front()));
         end
         if (t_rd_en) begin
            if (taddr_q.size() == 0) chk("t_rd_unexpected", 32'(t_rd_addr), 32'hFFFF);
            else chk("t_rd_addr", 32'(t_rd_addr), 32'(taddr_q.pop_front()));
         end
         if (valid_out) begin
            if (exp_q.size() == 0) chk("beat_unexpected", 32'(x), 32'hFFFF);
            else begin
               e = exp_q.pop_front();
               chk("x", 32'(x), 32'(e.x));
               chk("w", 32'(w), 32'(e.w));
               chk("last", 32'(last), 32'(e.last));
               if (e.last) chk("threshold", 32'(threshold), 32'(e.thr));
            end
            log_q.push_back('{x, w, last, threshold});
            beats_seen++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end else begin
            chk("last_on_gap", 32'(last), 32'd0);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_stream_drained", 32'(exp_q.size()), 32'd0);
            chk("busy_at_done", 32'(busy), 32'd0);
         end
         if (valid1) begin
            if (exp1_q.size() == 0) chk("b_beat_unexpected", 32'(x1), 32'hFFFF);
            else begin
               e = exp1_q.pop_front();
               chk("b_x", 32'(x1), 32'(e.x));
               chk("b_w", 32'(w1), 32'(e.w));
               chk("b_last", 32'(last1), 32'(e.last));
               chk("b_threshold", 32'(threshold1), 32'(e.thr));
            end
            beats1_seen++;
         end
         if (done1) begin
            done1_cnt++;
            done1_cyc = cyc;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      act_wr_en = 1'b1; act_wr_addr = a; act_wr_data = d;
      @(posedge clk); #1;
      act_wr_en = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      start_cyc = cyc;
      first_cyc = -1;
      log_q.delete();
      @(posedge clk); #1;
      start = 1'b0;
      act_wr_en = 1'b0;
   endtask

   task automatic wait_done(input int prev, input string nm);
      int n = 0;
      while (done_cnt == prev && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(done_cnt), 32'(prev + 1));
   endtask

   initial begin
      int prev, b0, n;
      act_wr_en = 0; act_wr_addr = 0; act_wr_data = 0; start = 0; pause = 0;
      act1_wr_en = 0; act1_wr_addr = 0; act1_wr_data = 0; start1 = 0; pause1 = 0;
      repeat (3) @(posedge clk); #1;

      // Reset state
      chk("rst_valid_out", 32'(valid_out), 0);
      chk("rst_last", 32'(last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_w_rd_en", 32'(w_rd_en), 0);
      chk("rst_t_rd_en", 32'(t_rd_en), 0);
      chk("rst_w_rd_addr", 32'(w_rd_addr), 0);
      chk("rst_t_rd_addr", 32'(t_rd_addr), 0);
      chk("rst_x", 32'(x), 0);
      chk("rst_threshold", 32'(threshold), 0);
`ifdef NEURON_FEEDER_PERF_CNT_EN
      chk("rst_cycle_cnt", cycle_cnt, 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Scenario 1: plain pass; last activation written in the start cycle
      act_m = '{8'hFF, 8'h00, 8'hAA, 8'h55};
      wr(0, 8'hFF); wr(1, 8'h00); wr(2, 8'hAA);
      push_pass();
      act_wr_en = 1'b1; act_wr_addr = 2'd3; act_wr_data = 8'h55;
      prev = done_cnt;
      go();
      chk("s1_busy", 32'(busy), 1);
      wait_done(prev, "s1_done_seen");
      chk("s1_done_latency", 32'(done_cyc - start_cyc), 14);
      chk("s1_beat_span", 32'(last_cyc - first_cyc), 11);
      chk("s1_beats", 32'(log_q.size()), 12);
      if (log_q.size() == 12) begin
         chk("s1_b0_x", 32'(log_q[0].x), 32'hFF);
         chk("s1_b3_x", 32'(log_q[3].x), 32'h55);
         chk("s1_b3_w", 32'(log_q[3].w), 3);
         chk("s1_b3_last", 32'(log_q[3].last), 1);
         chk("s1_b3_thr", 32'(log_q[3].thr), 10);
         chk("s1_b7_thr", 32'(log_q[7].thr), 20);
         chk("s1_b11_thr", 32'(log_q[11].thr), 30);
         chk("s1_b11_w", 32'(log_q[11].w), 11);
      end
      chk("s1_thr_held", 32'(threshold), 30);

      // Scenario 2: pause for 3 cycles after the 5th issue
      push_pass();
      prev = done_cnt;
      go();
      repeat (5) @(posedge clk); #1;
      pause = 1'b1;
      repeat (3) @(posedge clk); #1;
      pause = 1'b0;
      wait_done(prev, "s2_done_seen");
      chk("s2_done_latency", 32'(done_cyc - start_cyc), 17);
      chk("s2_beat_span", 32'(last_cyc - first_cyc), 14);
      chk("s2_beats", 32'(log_q.size()), 12);
`ifdef NEURON_FEEDER_PERF_CNT_EN
      chk("s2_cycle_cnt", cycle_cnt, 16);
`endif

      // Scenario 3: start and buffer write while running are ignored
      push_pass();
      prev = done_cnt;
      go();
      repeat (3) @(posedge clk); #1;
      start = 1'b1; act_wr_en = 1'b1; act_wr_addr = 2'd0; act_wr_data = 8'h12;
      @(posedge clk); #1;
      start = 1'b0; act_wr_en = 1'b0;
      wait_done(prev, "s3_done_seen");
      chk("s3_done_latency", 32'(done_cyc - start_cyc), 14);
      @(posedge clk); #1;
      chk("s3_no_restart", 32'(busy), 0);

      // Scenario 4: reset mid-pass, then a fresh pass
      push_pass();
      prev = done_cnt;
      b0 = beats_seen;
      go();
      n = 0;
      while (beats_seen < b0 + 6 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("s4_beats_before_rst", 32'(beats_seen - b0), 6);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("s4_rst_valid", 32'(valid_out), 0);
      chk("s4_rst_busy", 32'(busy), 0);
      chk("s4_rst_done", 32'(done), 0);
      chk("s4_rst_w_rd_en", 32'(w_rd_en), 0);
`ifdef NEURON_FEEDER_PERF_CNT_EN
      chk("s4_rst_cycle_cnt", cycle_cnt, 0);
`endif
      exp_q.delete(); addr_q.delete(); taddr_q.delete();
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("s4_no_done", 32'(done_cnt), 32'(prev));
      push_pass();
      go();
      wait_done(prev, "s4_done_seen");
      chk("s4_done_latency", 32'(done_cyc - start_cyc), 14);
      chk("s4_beats", 32'(log_q.size()), 12);
      if (log_q.size() == 12) begin
         chk("s4_b0_x", 32'(log_q[0].x), 32'hFF);
         chk("s4_b11_thr", 32'(log_q[11].thr), 30);
      end

      // Scenario 5: IN_BEATS=1, NUM_NEURONS=2 on the second instance
      act1_m = 8'h3C;
      act1_wr_en = 1'b1; act1_wr_addr = 1'b0; act1_wr_data = act1_m;
      @(posedge clk); #1;
      act1_wr_en = 1'b0;
      exp1_q.push_back('{act1_m, 8'd0, 1'b1, 16'd10});
      exp1_q.push_back('{act1_m, 8'd1, 1'b1, 16'd20});
      prev = done1_cnt;
      start1 = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 0;
      while (done1_cnt == prev && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("s5_done_seen", 32'(done1_cnt), 32'(prev + 1));
      chk("s5_done_latency", 32'(done1_cyc - start_cyc), 4);
      chk("s5_beats", 32'(beats1_seen), 2);
      chk("s5_drained", 32'(exp1_q.size()), 0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
